ksa_param: RTL and testbench
============================

Name: ksa_param

Overview:
- Parametrised RC4 key-scheduling engine; next generation of the fixed 24-bit, 256-entry KSA used by the task2 top level.
- Drives an external single-port synchronous S RAM with registered address and unregistered output, so read data is valid one cycle after the address.
- Key length and S-box size are generic.
- Uses a ready/enable handshake, matching the existing ksa/prga blocks.

Parameters:
- ADDR_W, 8, S-box index width. N = 2**ADDR_W entries; each entry is also ADDR_W bits wide.
- KEY_BYTES, 3, number of ADDR_W-bit key symbols. Key width = KEY_BYTES*ADDR_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; honoured only while rdy=1
- rdy  out  1  1 = idle and able to accept en
- done  out  1  one-cycle pulse when a run completes
- key  in  KEY_BYTES*ADDR_W  key value, sampled on the accepted en cycle
- addr  out  ADDR_W  S RAM address
- rddata  in  ADDR_W  S RAM read data, valid 1 cycle after addr
- wrdata  out  ADDR_W  S RAM write data
- wren  out  1  S RAM write enable

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, rdy=1, done=0, wren=0, addr=0, wrdata=0, i=0, j=0, key register=0.
- Handshake:
  - en is accepted when en=1 and rdy=1 on a rising edge; key is latched on that edge.
  - rdy=0 from the next cycle until the run ends.
  - en while rdy=0 is ignored and the latched key is unaffected.
- Key symbol ordering: symbol k (k = i mod KEY_BYTES) is key[(KEY_BYTES-k)*ADDR_W-1 -: ADDR_W], i.e. big-endian. Symbol 0 is the most significant.
- Arithmetic: j_next = (j + S[i] + key_sym) mod N, using ADDR_W-bit wrapping adds.
- Swap FSM states, one per cycle:
  - RD_I: addr=i, wren=0.
  - LAT_I: capture si=rddata; compute j_next.
  - RD_J: addr=j_next, wren=0; j <= j_next.
  - LAT_J: capture sj=rddata.
  - WR_I: addr=i, wrdata=sj, wren=1.
  - WR_J: addr=j, wrdata=si, wren=1. If i==N-1, go to FIN; otherwise i <= i+1 and go to RD_I.
- i==j case: both writes hit the same address with the same original value. No special case is needed and S is unchanged.
- FIN: one cycle with done=1, wren=0, i=0, j=0; next state IDLE with rdy=1.
- Timing without init: the accepted en edge enters RD_I on the next cycle. Swap phase = 6*N cycles; done asserts in cycle 6*N+1 after acceptance, with rdy=1 the following cycle.
  - ADDR_W=8: done at 1537.
- wren is high only in WR_I, WR_J and INIT. addr/wrdata outside those states hold their last value. Consumers must gate on wren.
- Back-to-back runs: en asserted on the same cycle rdy returns high is accepted.
- Reset mid-operation: immediate return to reset values. No write occurs after rst_n falls; S RAM contents are left partially permuted.

Optional Feature:
- Macro: KSA_INIT_EN.
- Defined:
  - An INIT state precedes RD_I: addr=n, wrdata=n, wren=1 for n=0..N-1, one write per cycle.
  - Adds N cycles; ADDR_W=8 done arrives at 1793.
  - Block is self-contained regardless of prior RAM contents.
- Undefined:
  - No INIT state; the caller must preload S[n]=n, e.g. via the existing init block.
  - Timing as in Behaviour.

Test Plan:
1. Reset: rst_n=0 with clk running -> rdy=1, done=0, wren=0, addr=0. rst_n=1 with no en -> no RAM activity for 100 cycles.
2. Default params, RAM preloaded identity, key=24'h00033C, pulse en -> done at cycle 1537, rdy=1 at 1538. RAM matches the golden software KSA; spot-check S[0] and S[255] against the model.
3. KEY_BYTES=1, ADDR_W=4, identity preload, key=4'hA -> done at cycle 97. All 16 entries match the golden model and form a permutation of 0..15.
4. en re-asserted with key=24'hFFFFFF at cycles 10 and 500 of a run started with key=24'h00033C -> result identical to scenario 2; exactly one done pulse.
5. rst_n low at cycle 700 -> wren=0 immediately, rdy=1. A fresh en with key=24'h00033C after reloading identity -> result equals scenario 2.
6. KSA_INIT_EN defined, RAM preloaded with 8'hAA everywhere, key=24'h00033C -> done at cycle 1793. Result equals scenario 2. Second back-to-back run gives an identical result.

Source files
------------

// File: rtl/ksa_param.sv
`default_nettype none
// ============================================================================
//  Module   : ksa_param
//  Purpose  : Parametrised RC4 key-scheduling engine. Walks i = 0..N-1 and
//             swaps S[i] with S[j] in an external single-port synchronous
//             S RAM. The RAM registers its address, so read data is valid
//             one cycle after the address is presented.
//             N = 2**ADDR_W entries, each ADDR_W bits wide.
//             The key is KEY_BYTES symbols, big-endian: symbol 0 is the
//             most significant ADDR_W bits of key.
//  Options  : KSA_INIT_EN - when defined, an INIT phase writes S[n] = n
//             for every n before the swap phase. The engine then does not
//             depend on the RAM contents left by earlier activity. When it is
//             undefined, the caller must preload the identity permutation.
//  Revision : 1.0 - initial release
// ============================================================================
module ksa_param #(
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    output logic                          rdy,
    output logic                          done,
    input  logic [KEY_BYTES*ADDR_W-1:0]   key,
    output logic [ADDR_W-1:0]             addr,
    input  logic [ADDR_W-1:0]             rddata,
    output logic [ADDR_W-1:0]             wrdata,
    output logic                          wren
);

    // The key symbol index needs at least one bit even for a one-symbol key.
    localparam int                KIDX_W      = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_W-1:0] C_LAST      = '1;
    localparam logic [KIDX_W-1:0] C_KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

    // One state per swap step, plus idle, the optional init sweep, and the
    // completion cycle.
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        INIT  = 4'd1,
        RD_I  = 4'd2,
        LAT_I = 4'd3,
        RD_J  = 4'd4,
        LAT_J = 4'd5,
        WR_I  = 4'd6,
        WR_J  = 4'd7,
        FIN   = 4'd8
    } state_t;

    state_t                        r_state;
    logic [ADDR_W-1:0]             r_i;
    logic [ADDR_W-1:0]             r_j;
    logic [ADDR_W-1:0]             r_si;
    logic [KEY_BYTES*ADDR_W-1:0]   r_key;
    // r_kidx tracks i mod KEY_BYTES incrementally, so no divider is needed.
    logic [KIDX_W-1:0]             r_kidx;

    logic [ADDR_W-1:0]             w_key_sym;
    logic [ADDR_W-1:0]             w_j_next;

    // Select the current key symbol, big-endian (symbol 0 = top bits).
    always_comb begin
        w_key_sym = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (r_kidx == KIDX_W'(b)) begin
                w_key_sym = r_key[(KEY_BYTES - b)*ADDR_W-1 -: ADDR_W];
            end
        end
    end

    // The adds wrap naturally at ADDR_W bits, which gives mod N.
    // rddata is S[i] while the FSM is in LAT_I.
    assign w_j_next = r_j + rddata + w_key_sym;

    // Main FSM. All RAM-facing outputs are registered, so each state sets
    // up the outputs that the next state presents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            rdy     <= 1'b1;
            done    <= 1'b0;
            wren    <= 1'b0;
            addr    <= '0;
            wrdata  <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_si    <= '0;
            r_key   <= '0;
            r_kidx  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (en) begin
                        // The key is latched only here. en while busy
                        // never reaches this branch.
                        r_key  <= key;
                        rdy    <= 1'b0;
                        r_i    <= '0;
                        r_j    <= '0;
                        r_kidx <= '0;
                        addr   <= '0;
`ifdef KSA_INIT_EN
                        wrdata  <= '0;
                        wren    <= 1'b1;
                        r_state <= INIT;
`else
                        r_state <= RD_I;
`endif
                    end
                end

`ifdef KSA_INIT_EN
                // Write S[n] = n, one entry per cycle. r_i is the sweep counter.
                INIT: begin
                    if (r_i == C_LAST) begin
                        r_i     <= '0;
                        addr    <= '0;
                        wren    <= 1'b0;
                        r_state <= RD_I;
                    end else begin
                        r_i    <= r_i + 1'b1;
                        addr   <= r_i + 1'b1;
                        wrdata <= r_i + 1'b1;
                    end
                end
`endif

                // addr = i is on the bus. The RAM registers it on this edge.
                RD_I: begin
                    r_state <= LAT_I;
                end

                // S[i] is valid. Latch it and move to reading S[j_next].
                LAT_I: begin
                    r_si    <= rddata;
                    r_j     <= w_j_next;
                    addr    <= w_j_next;
                    r_state <= RD_J;
                end

                RD_J: begin
                    r_state <= LAT_J;
                end

                // S[j] is valid. It goes straight out as the first write's data.
                LAT_J: begin
                    addr    <= r_i;
                    wrdata  <= rddata;
                    wren    <= 1'b1;
                    r_state <= WR_I;
                end

                // Second half of the swap. When i == j, both writes store the
                // same original value, so S is unchanged.
                WR_I: begin
                    addr    <= r_j;
                    wrdata  <= r_si;
                    r_state <= WR_J;
                end

                WR_J: begin
                    wren <= 1'b0;
                    if (r_i == C_LAST) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_kidx  <= '0;
                        done    <= 1'b1;
                        r_state <= FIN;
                    end else begin
                        r_i     <= r_i + 1'b1;
                        addr    <= r_i + 1'b1;
                        r_kidx  <= (r_kidx == C_KIDX_LAST) ? '0 : r_kidx + 1'b1;
                        r_state <= RD_I;
                    end
                end

                // done is high for exactly this cycle. rdy returns next cycle.
                FIN: begin
                    done    <= 1'b0;
                    rdy     <= 1'b1;
                    r_state <= IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    wren    <= 1'b0;
                    rdy     <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ksa_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ksa_param
//  Purpose  : Directed bench for ksa_param. It drives an 8-bit/3-symbol
//             instance and a 4-bit/1-symbol instance, each connected to a
//             behavioural S RAM. Results are checked against hand-computed
//             values and a software KSA.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ksa_param;

`ifdef KSA_INIT_EN
    localparam int  DONE8  = 1793;
    localparam int  DONE4  = 113;
    localparam bit  PRE_ID = 1'b0;
`else
    localparam int  DONE8  = 1537;
    localparam int  DONE4  = 97;
    localparam bit  PRE_ID = 1'b1;
`endif
    localparam int TIMEOUT = 4000;

    logic        clk;
    logic        rst_n;

    logic        en8, rdy8, done8, wren8;
    logic [23:0] key8;
    logic [7:0]  addr8, rddata8, wrdata8, addr8_q;
    logic [7:0]  mem8 [256];
    logic [7:0]  g8   [256];
    logic [7:0]  snap8[256];
    logic        fill8_req, fill8_id;

    logic        en4, rdy4, done4, wren4;
    logic [3:0]  key4;
    logic [3:0]  addr4, rddata4, wrdata4, addr4_q;
    logic [3:0]  mem4 [16];
    logic        fill4_req;

    logic [3:0]  exp4 [16];

    int n_tests;
    int n_fail;

    ksa_param #(.ADDR_W(8), .KEY_BYTES(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .rdy(rdy8), .done(done8),
        .key(key8), .addr(addr8), .rddata(rddata8), .wrdata(wrdata8), .wren(wren8)
    );

    ksa_param #(.ADDR_W(4), .KEY_BYTES(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .rdy(rdy4), .done(done4),
        .key(key4), .addr(addr4), .rddata(rddata4), .wrdata(wrdata4), .wren(wren4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // S RAMs: the address is registered and the output is unregistered.
    // A fill request overrides writes.
    always @(posedge clk) begin
        if (fill8_req) begin
            for (int k = 0; k < 256; k++) mem8[k] <= fill8_id ? 8'(k) : 8'hAA;
        end else if (wren8) begin
            mem8[addr8] <= wrdata8;
        end
        addr8_q <= addr8;
    end
    assign rddata8 = mem8[addr8_q];

    always @(posedge clk) begin
        if (fill4_req) begin
            for (int k = 0; k < 16; k++) mem4[k] <= 4'(k);
        end else if (wren4) begin
            mem4[addr4] <= wrdata4;
        end
        addr4_q <= addr4;
    end
    assign rddata4 = mem4[addr4_q];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill8(input bit id);
        @(negedge clk);
        fill8_req = 1'b1;
        fill8_id  = id;
        @(negedge clk);
        fill8_req = 1'b0;
    endtask

    task automatic golden_identity();
        for (int k = 0; k < 256; k++) g8[k] = 8'(k);
    endtask

    // Software KSA applied in place to g8.
    task automatic model8(input logic [23:0] k);
        logic [7:0] j;
        logic [7:0] t;
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            j     = j + g8[i] + k[(2 - (i % 3))*8 +: 8];
            t     = g8[i];
            g8[i] = g8[j];
            g8[j] = t;
        end
    endtask

    function automatic int diff8();
        int d;
        d = 0;
        for (int k = 0; k < 256; k++) if (mem8[k] !== g8[k]) d++;
        return d;
    endfunction

    // Start one run on the 8-bit engine and follow it to completion.
    // chain=1 means the caller is already in a rdy cycle, so en is raised at
    // once. inject raises en with an all-ones key at run cycles 10 and 500.
    // rst_at>0 pulls rst_n low in that run cycle and returns.
    task automatic run8(input logic [23:0] k, input bit inject, input int rst_at,
                        input bit chain, output int done_cyc, output int pulses);
        int c;
        done_cyc = -1;
        pulses   = 0;
        if (!chain) @(negedge clk);
        en8  = 1'b1;
        key8 = k;
        @(posedge clk); #1;
        en8 = 1'b0;
        c   = 1;
        while (c < TIMEOUT) begin
            if (done8) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                check("rdy_after_done", 32'(rdy8), 32'd1);
                break;
            end
            if (inject && (c == 10 || c == 500)) begin
                en8  = 1'b1;
                key8 = 24'hFFFFFF;
            end else begin
                en8 = 1'b0;
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        en8 = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, np, act, d, c4;
        logic [7:0]  a0;
        logic [15:0] seen;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        en8       = 1'b0;
        en4       = 1'b0;
        key8      = '0;
        key4      = '0;
        fill8_req = 1'b0;
        fill8_id  = 1'b1;
        fill4_req = 1'b0;

        // Hand-worked KSA on S = 0..15 with key symbol 0xA.
        exp4 = '{4'd10, 4'd2, 4'd15, 4'd14, 4'd12, 4'd4, 4'd1, 4'd8,
                 4'd9, 4'd3, 4'd7, 4'd6, 4'd13, 4'd0, 4'd11, 4'd5};

        // Reset values with the clock running.
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy",    32'(rdy8),    32'd1);
        check("rst_done",   32'(done8),   32'd0);
        check("rst_wren",   32'(wren8),   32'd0);
        check("rst_addr",   32'(addr8),   32'd0);
        check("rst_wrdata", 32'(wrdata8), 32'd0);
        check("rst_rdy4",   32'(rdy4),    32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: no RAM activity without en.
        act = 0;
        a0  = addr8;
        repeat (100) begin
            @(posedge clk); #1;
            if (wren8 || wren4 || addr8 != a0 || done8 || !rdy8) act++;
        end
        check("idle_activity", act, 0);

        // Default key on the identity permutation, then a back-to-back second run.
        fill8(PRE_ID);
        golden_identity();
        model8(24'h00033C);
        run8(24'h00033C, 1'b0, 0, 1'b0, dc, np);
        check("s2_done_cyc", dc, DONE8);
        check("s2_pulses",   np, 1);
        check("s2_ram",      diff8(), 0);
        check("s2_s0",       32'(mem8[0]),   32'(g8[0]));
        check("s2_s255",     32'(mem8[255]), 32'(g8[255]));
`ifndef KSA_INIT_EN
        // Without init, the second run permutes the first run's result again.
        model8(24'h00033C);
`endif
        run8(24'h00033C, 1'b0, 0, 1'b1, dc, np);
        check("b2b_done_cyc", dc, DONE8);
        check("b2b_ram",      diff8(), 0);

        // 4-bit S-box with a one-symbol key.
        @(negedge clk);
        fill4_req = 1'b1;
        @(negedge clk);
        fill4_req = 1'b0;
        en4  = 1'b1;
        key4 = 4'hA;
        @(posedge clk); #1;
        en4 = 1'b0;
        c4  = 1;
        while (!done4 && c4 < TIMEOUT) begin
            @(posedge clk); #1;
            c4++;
        end
        check("s3_done_cyc", c4, DONE4);
        d    = 0;
        seen = '0;
        for (int k = 0; k < 16; k++) begin
            if (mem4[k] !== exp4[k]) d++;
            seen[mem4[k]] = 1'b1;
        end
        check("s3_ram",  d, 0);
        check("s3_s0",   32'(mem4[0]),  32'd10);
        check("s3_s15",  32'(mem4[15]), 32'd5);
        check("s3_perm", 32'(seen),     32'hFFFF);

        // en during a run is ignored, along with its key.
        fill8(PRE_ID);
        golden_identity();
        model8(24'h00033C);
        run8(24'h00033C, 1'b1, 0, 1'b0, dc, np);
        check("s4_done_cyc", dc, DONE8);
        check("s4_pulses",   np, 1);
        check("s4_ram",      diff8(), 0);

        // Asynchronous reset in the middle of a write pair.
        fill8(1'b1);
        run8(24'h00033C, 1'b0, 701, 1'b0, dc, np);
        #1;
        check("s5_wren", 32'(wren8), 32'd0);
        check("s5_rdy",  32'(rdy8),  32'd1);
        check("s5_done", 32'(done8), 32'd0);
        for (int k = 0; k < 256; k++) snap8[k] = mem8[k];
        repeat (3) @(posedge clk);
        #1;
        d = 0;
        for (int k = 0; k < 256; k++) if (mem8[k] !== snap8[k]) d++;
        check("s5_no_write", d, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill8(1'b1);
        run8(24'h00033C, 1'b0, 0, 1'b0, dc, np);
        check("s5_done_cyc", dc, DONE8);
        check("s5_ram",      diff8(), 0);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
